writeback_control: RTL and testbench

Closes the pipeline loop. Holds the MEM/WB pipeline register and drives the register-file write port back into decode. Generates the load-use `hazard` stall and both EX-stage forwarding selects, replacing the constant stimulus currently tied to those nets. Keeps 32-bit performance counters for cycles, stalls and retired register writes.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/forward_select.sv | 38 +++
 rtl/writeback_control.sv | 135 +++++++++++++
 tb/tb_writeback_control.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the write-back / hazard logic of the
//   five-stage pipeline.
//   - REG_ADDR_W / DATA_W : register-address and datapath widths.
//   - fwd_sel_e           : EX operand forwarding select encoding.
//   - mem_wb_t            : contents of the MEM/WB pipeline register.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Where the EX stage takes an operand from. 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // value read from the ID/EX register
        FWD_WB  = 2'b01,   // write-back data (writeData)
        FWD_MEM = 2'b10    // MEM-stage ALU result
    } fwd_sel_e;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     mem_data;
    } mem_wb_t;

endpackage

// File: rtl/forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
//   Forwarding select for one EX-stage source operand.
//   Ports:
//     operand_i        : EX-stage source register address
//     mem_reg_write_i  : MEM-stage instruction writes a register
//     mem_to_reg_i     : MEM-stage instruction is a load
//     mem_rd_i         : MEM-stage destination register
//     wb_reg_write_i   : WB-stage write enable (already excludes $0)
//     wb_rd_i          : WB-stage destination register
//     sel_o            : operand source select
// -----------------------------------------------------------------------------
module forward_select
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] operand_i,
    input  logic                  mem_reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output fwd_sel_e              sel_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives sel_o (no latch).
        sel_o = FWD_REG;
        if (operand_i != '0) begin
            // A load in MEM has no data yet; the stall moves it to WB instead.
            if (mem_reg_write_i && !mem_to_reg_i && (mem_rd_i == operand_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_reg_write_i && (wb_rd_i == operand_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/writeback_control.sv
// -----------------------------------------------------------------------------
// writeback_control
//   MEM/WB pipeline register, register-file write port, load-use hazard
//   detection, EX forwarding selects and performance counters.
//   Ports:
//     clk, reset                       : clock, async active-low reset
//     memToRegMem, regWriteMem         : MEM-stage controls
//     regWriteRegisterMem              : MEM-stage destination register
//     aluResultMem, dataMemoryMem      : MEM-stage ALU result / load data
//     memReadEx, regWriteEx            : EX-stage controls
//     addressRsEx, addressRtEx         : EX-stage source registers
//     addressRsId, addressRtId         : ID-stage source registers
//     regWriteWb, writeRegisterWb      : register-file write enable / address
//     writeData                        : register-file write data (also WB fwd)
//     hazard                           : load-use stall request
//     forwardingMux0Ex/1Ex             : rs / rt operand selects
//     cycleCount/stallCount/retiredCount : wrapping performance counters
// -----------------------------------------------------------------------------
module writeback_control
    import pipeline_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memToRegMem,
    input  logic                     regWriteMem,
    input  logic [REG_ADDR_W-1:0]    regWriteRegisterMem,
    input  logic [DATA_W-1:0]        aluResultMem,
    input  logic [DATA_W-1:0]        dataMemoryMem,
    input  logic                     memReadEx,
    input  logic                     regWriteEx,
    input  logic [REG_ADDR_W-1:0]    addressRsEx,
    input  logic [REG_ADDR_W-1:0]    addressRtEx,
    input  logic [REG_ADDR_W-1:0]    addressRsId,
    input  logic [REG_ADDR_W-1:0]    addressRtId,
    output logic                     regWriteWb,
    output logic [REG_ADDR_W-1:0]    writeRegisterWb,
    output logic [DATA_W-1:0]        writeData,
    output logic                     hazard,
    output logic [1:0]               forwardingMux0Ex,
    output logic [1:0]               forwardingMux1Ex,
    output logic [COUNTER_WIDTH-1:0] cycleCount,
    output logic [COUNTER_WIDTH-1:0] stallCount,
    output logic [COUNTER_WIDTH-1:0] retiredCount
);

    // ---------------- MEM/WB register ----------------
    mem_wb_t mem_wb_d, mem_wb_q;

    always_comb begin
        mem_wb_d = '{
            mem_to_reg: memToRegMem,
            reg_write:  regWriteMem,
            rd:         regWriteRegisterMem,
            alu_result: aluResultMem,
            mem_data:   dataMemoryMem
        };
    end

    // NOTE: sequential state uses non-blocking assignments only; the register
    // is small enough that clearing it in reset costs nothing and guarantees
    // no stray write after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // ---------------- Write-back port ----------------
    assign regWriteWb      = mem_wb_q.reg_write && (mem_wb_q.rd != '0);
    assign writeRegisterWb = mem_wb_q.rd;
    assign writeData       = mem_wb_q.mem_to_reg ? mem_wb_q.mem_data : mem_wb_q.alu_result;

    // ---------------- Load-use hazard ----------------
    assign hazard = memReadEx && regWriteEx && (addressRtEx != '0) &&
                    ((addressRtEx == addressRsId) || (addressRtEx == addressRtId));

    // ---------------- Forwarding ----------------
    fwd_sel_e fwd_rs, fwd_rt;

    forward_select u_fwd_rs (
        .operand_i       (addressRsEx),
        .mem_reg_write_i (regWriteMem),
        .mem_to_reg_i    (memToRegMem),
        .mem_rd_i        (regWriteRegisterMem),
        .wb_reg_write_i  (regWriteWb),
        .wb_rd_i         (writeRegisterWb),
        .sel_o           (fwd_rs)
    );

    forward_select u_fwd_rt (
        .operand_i       (addressRtEx),
        .mem_reg_write_i (regWriteMem),
        .mem_to_reg_i    (memToRegMem),
        .mem_rd_i        (regWriteRegisterMem),
        .wb_reg_write_i  (regWriteWb),
        .wb_rd_i         (writeRegisterWb),
        .sel_o           (fwd_rt)
    );

    assign forwardingMux0Ex = fwd_rs;
    assign forwardingMux1Ex = fwd_rt;

    // ---------------- Performance counters ----------------
    logic [COUNTER_WIDTH-1:0] cycle_d,   cycle_q;
    logic [COUNTER_WIDTH-1:0] stall_d,   stall_q;
    logic [COUNTER_WIDTH-1:0] retired_d, retired_q;

    // Natural unsigned overflow gives the modulo-2^COUNTER_WIDTH wrap.
    always_comb begin
        cycle_d   = cycle_q   + COUNTER_WIDTH'(1);
        stall_d   = stall_q   + COUNTER_WIDTH'(hazard);
        retired_d = retired_q + COUNTER_WIDTH'(regWriteWb);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            stall_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            retired_q <= retired_d;
        end
    end

    assign cycleCount   = cycle_q;
    assign stallCount   = stall_q;
    assign retiredCount = retired_q;

endmodule

// File: tb/tb_writeback_control.sv
// -----------------------------------------------------------------------------
// tb_writeback_control
//   Self-checking bench. Expected write-back results are queued when MEM-stage
//   stimulus is driven and compared when the DUT presents them one edge later.
//   A second instance with COUNTER_WIDTH = 4 shares the stimulus for the
//   counter-wrap scenario.
// -----------------------------------------------------------------------------
module tb_writeback_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        memToRegMem, regWriteMem;
    logic [4:0]  regWriteRegisterMem;
    logic [31:0] aluResultMem, dataMemoryMem;
    logic        memReadEx, regWriteEx;
    logic [4:0]  addressRsEx, addressRtEx, addressRsId, addressRtId;

    logic        regWriteWb;
    logic [4:0]  writeRegisterWb;
    logic [31:0] writeData;
    logic        hazard;
    logic [1:0]  forwardingMux0Ex, forwardingMux1Ex;
    logic [31:0] cycleCount, stallCount, retiredCount;

    logic        regWriteWb4, hazard4;
    logic [4:0]  writeRegisterWb4;
    logic [31:0] writeData4;
    logic [1:0]  fwd0_4, fwd1_4;
    logic [3:0]  cycleCount4, stallCount4, retiredCount4;

    always #5 clk = ~clk;

    writeback_control dut (
        .clk(clk), .reset(reset),
        .memToRegMem(memToRegMem), .regWriteMem(regWriteMem),
        .regWriteRegisterMem(regWriteRegisterMem),
        .aluResultMem(aluResultMem), .dataMemoryMem(dataMemoryMem),
        .memReadEx(memReadEx), .regWriteEx(regWriteEx),
        .addressRsEx(addressRsEx), .addressRtEx(addressRtEx),
        .addressRsId(addressRsId), .addressRtId(addressRtId),
        .regWriteWb(regWriteWb), .writeRegisterWb(writeRegisterWb),
        .writeData(writeData), .hazard(hazard),
        .forwardingMux0Ex(forwardingMux0Ex), .forwardingMux1Ex(forwardingMux1Ex),
        .cycleCount(cycleCount), .stallCount(stallCount), .retiredCount(retiredCount)
    );

    writeback_control #(.COUNTER_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .memToRegMem(memToRegMem), .regWriteMem(regWriteMem),
        .regWriteRegisterMem(regWriteRegisterMem),
        .aluResultMem(aluResultMem), .dataMemoryMem(dataMemoryMem),
        .memReadEx(memReadEx), .regWriteEx(regWriteEx),
        .addressRsEx(addressRsEx), .addressRtEx(addressRtEx),
        .addressRsId(addressRsId), .addressRtId(addressRtId),
        .regWriteWb(regWriteWb4), .writeRegisterWb(writeRegisterWb4),
        .writeData(writeData4), .hazard(hazard4),
        .forwardingMux0Ex(fwd0_4), .forwardingMux1Ex(fwd1_4),
        .cycleCount(cycleCount4), .stallCount(stallCount4), .retiredCount(retiredCount4)
    );

    typedef struct {
        logic        mtr, rwm;
        logic [4:0]  rdm;
        logic [31:0] alu, dmem;
        logic        mre, rwe;
        logic [4:0]  rs_ex, rt_ex, rs_id, rt_id;
    } stim_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench model of the WB stage and counters.
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] exp_cycle, exp_stall, exp_retired;

    function automatic stim_t idle();
        stim_t s;
        s = '{mtr: 1'b0, rwm: 1'b0, rdm: 5'd0, alu: 32'd0, dmem: 32'd0,
              mre: 1'b0, rwe: 1'b0, rs_ex: 5'd0, rt_ex: 5'd0, rs_id: 5'd0, rt_id: 5'd0};
        return s;
    endfunction

    function automatic logic [1:0] fwd_model(logic [4:0] op, stim_t s);
        if (op == 5'd0) return 2'b00;
        if (s.rwm && !s.mtr && (s.rdm == op)) return 2'b10;
        if (m_we && (m_rd == op)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_model();
        m_we = 1'b0; m_rd = '0; m_data = '0;
        exp_cycle = '0; exp_stall = '0; exp_retired = '0;
        sb.delete();
    endtask

    task automatic drive(stim_t s);
        memToRegMem = s.mtr; regWriteMem = s.rwm; regWriteRegisterMem = s.rdm;
        aluResultMem = s.alu; dataMemoryMem = s.dmem;
        memReadEx = s.mre; regWriteEx = s.rwe;
        addressRsEx = s.rs_ex; addressRtEx = s.rt_ex;
        addressRsId = s.rs_id; addressRtId = s.rt_id;
    endtask

    // Called at a falling edge: drives one cycle of stimulus, checks the
    // combinational outputs and queues the expected write-back.
    task automatic apply(stim_t s);
        logic       e_haz;
        logic [1:0] e_f0, e_f1;
        wb_exp_t    e;
        drive(s);
        #1;
        e_haz = s.mre && s.rwe && (s.rt_ex != 5'd0) &&
                ((s.rt_ex == s.rs_id) || (s.rt_ex == s.rt_id));
        e_f0 = fwd_model(s.rs_ex, s);
        e_f1 = fwd_model(s.rt_ex, s);
        n_checks++;
        if (hazard !== e_haz) begin
            n_fail++; $display("FAIL hazard: got %b expected %b", hazard, e_haz);
        end
        n_checks++;
        if (forwardingMux0Ex !== e_f0) begin
            n_fail++; $display("FAIL fwd0: got %b expected %b", forwardingMux0Ex, e_f0);
        end
        n_checks++;
        if (forwardingMux1Ex !== e_f1) begin
            n_fail++; $display("FAIL fwd1: got %b expected %b", forwardingMux1Ex, e_f1);
        end
        e.we   = s.rwm && (s.rdm != 5'd0);
        e.rd   = s.rdm;
        e.data = s.mtr ? s.dmem : s.alu;
        sb.push_back(e);
        exp_stall   = exp_stall + 32'(e_haz);
        exp_retired = exp_retired + 32'(m_we);
        exp_cycle   = exp_cycle + 32'd1;
    endtask

    // Advances one rising edge, compares the popped write-back and counters,
    // and returns at the next falling edge.
    task automatic advance();
        wb_exp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (regWriteWb !== e.we) begin
                n_fail++; $display("FAIL regWriteWb: got %b expected %b", regWriteWb, e.we);
            end
            n_checks++;
            if (writeRegisterWb !== e.rd) begin
                n_fail++; $display("FAIL writeRegisterWb: got %0d expected %0d", writeRegisterWb, e.rd);
            end
            n_checks++;
            if (writeData !== e.data) begin
                n_fail++; $display("FAIL writeData: got %h expected %h", writeData, e.data);
            end
            m_we = e.we; m_rd = e.rd; m_data = e.data;
        end
        n_checks++;
        if (cycleCount !== exp_cycle) begin
            n_fail++; $display("FAIL cycleCount: got %0d expected %0d", cycleCount, exp_cycle);
        end
        n_checks++;
        if (stallCount !== exp_stall) begin
            n_fail++; $display("FAIL stallCount: got %0d expected %0d", stallCount, exp_stall);
        end
        n_checks++;
        if (retiredCount !== exp_retired) begin
            n_fail++; $display("FAIL retiredCount: got %0d expected %0d", retiredCount, exp_retired);
        end
        n_checks++;
        if (cycleCount4 !== exp_cycle[3:0]) begin
            n_fail++; $display("FAIL cycleCount4: got %0d expected %0d", cycleCount4, exp_cycle[3:0]);
        end
        @(negedge clk);
    endtask

    task automatic expect_all_zero(string tag);
        n_checks++;
        if ({regWriteWb, writeRegisterWb, writeData, hazard, forwardingMux0Ex, forwardingMux1Ex} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: got we=%b rd=%0d data=%h haz=%b f0=%b f1=%b expected all 0",
                     tag, regWriteWb, writeRegisterWb, writeData, hazard, forwardingMux0Ex, forwardingMux1Ex);
        end
        n_checks++;
        if ({cycleCount, stallCount, retiredCount, cycleCount4} !== '0) begin
            n_fail++;
            $display("FAIL %s counters: got %0d %0d %0d %0d expected 0", tag,
                     cycleCount, stallCount, retiredCount, cycleCount4);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(idle());
        clear_model();
        #2;
        expect_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mem_forward();
        stim_t s;
        s = idle();
        s.rwm = 1'b1; s.rdm = 5'd3; s.alu = 32'h1111_0003; s.rs_ex = 5'd3;
        apply(s);
        n_checks++;
        if (forwardingMux0Ex !== 2'b10) begin
            n_fail++; $display("FAIL mem_fwd_rs: got %b expected 10", forwardingMux0Ex);
        end
        advance();
        s = idle();
        s.rs_ex = 5'd3;
        apply(s);
        n_checks++;
        if (forwardingMux0Ex !== 2'b01 || writeData !== 32'h1111_0003) begin
            n_fail++; $display("FAIL wb_fwd_rs: got sel=%b data=%h expected 01 11110003",
                               forwardingMux0Ex, writeData);
        end
        advance();
    endtask

    task automatic test_load_use();
        stim_t s;
        // lw $5 in EX, dependent instruction in ID reads rt = 5.
        s = idle();
        s.mre = 1'b1; s.rwe = 1'b1; s.rt_ex = 5'd5; s.rt_id = 5'd5; s.rs_id = 5'd1;
        apply(s);
        n_checks++;
        if (hazard !== 1'b1) begin
            n_fail++; $display("FAIL load_use_hazard: got %b expected 1", hazard);
        end
        advance();
        n_checks++;
        if (stallCount !== 32'd1) begin
            n_fail++; $display("FAIL load_use_stalls: got %0d expected 1", stallCount);
        end
        // Bubble in EX, load now in MEM: no hazard, no MEM forward of a load.
        s = idle();
        s.mtr = 1'b1; s.rwm = 1'b1; s.rdm = 5'd5; s.alu = 32'h0000_0100; s.dmem = 32'hDEAD_BEEF;
        s.rt_id = 5'd5; s.rs_id = 5'd1;
        apply(s);
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++; $display("FAIL hazard_one_cycle: got %b expected 0", hazard);
        end
        advance();
        // Dependent instruction in EX, load in WB.
        s = idle();
        s.rs_ex = 5'd1; s.rt_ex = 5'd5;
        apply(s);
        n_checks++;
        if (writeData !== 32'hDEAD_BEEF || forwardingMux1Ex !== 2'b01) begin
            n_fail++; $display("FAIL load_wb_fwd: got data=%h sel=%b expected deadbeef 01",
                               writeData, forwardingMux1Ex);
        end
        advance();
    endtask

    task automatic test_mem_wb_priority();
        stim_t s;
        s = idle();
        s.rwm = 1'b1; s.rdm = 5'd7; s.alu = 32'hAAAA_0007;
        apply(s);
        advance();
        s.alu = 32'hBBBB_0007; s.rs_ex = 5'd7; s.rt_ex = 5'd7;
        apply(s);
        n_checks++;
        if (forwardingMux0Ex !== 2'b10 || forwardingMux1Ex !== 2'b10) begin
            n_fail++; $display("FAIL mem_over_wb: got %b %b expected 10 10",
                               forwardingMux0Ex, forwardingMux1Ex);
        end
        advance();
    endtask

    task automatic test_zero_dest();
        stim_t    s;
        logic [31:0] r0;
        s = idle();
        s.rwm = 1'b1; s.rdm = 5'd0; s.alu = 32'h1234_5678;
        apply(s);
        advance();
        r0 = retiredCount;
        s = idle();
        apply(s);
        n_checks++;
        if (regWriteWb !== 1'b0 || forwardingMux0Ex !== 2'b00 || forwardingMux1Ex !== 2'b00) begin
            n_fail++; $display("FAIL zero_dest: got we=%b f0=%b f1=%b expected 0 00 00",
                               regWriteWb, forwardingMux0Ex, forwardingMux1Ex);
        end
        advance();
        n_checks++;
        if (retiredCount !== r0) begin
            n_fail++; $display("FAIL zero_dest_retired: got %0d expected %0d", retiredCount, r0);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        for (int i = 0; i < 40; i++) begin
            s.mtr = 1'($urandom_range(0, 1));
            s.rwm = 1'($urandom_range(0, 1));
            s.rdm = 5'($urandom_range(0, 7));
            s.alu = $urandom;
            s.dmem = $urandom;
            s.mre = 1'($urandom_range(0, 1));
            s.rwe = 1'($urandom_range(0, 1));
            s.rs_ex = 5'($urandom_range(0, 7));
            s.rt_ex = 5'($urandom_range(0, 7));
            s.rs_id = 5'($urandom_range(0, 7));
            s.rt_id = 5'($urandom_range(0, 7));
            apply(s);
            advance();
        end
    endtask

    task automatic test_mid_run_reset();
        stim_t s;
        s = idle();
        s.rwm = 1'b1; s.rdm = 5'd9; s.alu = 32'h0000_0099;
        drive(s);
        reset = 1'b0;
        #1;
        expect_all_zero("mid_reset");
        @(posedge clk);
        #1;
        expect_all_zero("held_reset");
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        apply(s);
        advance();
        n_checks++;
        if (regWriteWb !== 1'b1 || writeData !== 32'h0000_0099) begin
            n_fail++; $display("FAIL first_write: got we=%b data=%h expected 1 00000099",
                               regWriteWb, writeData);
        end
    endtask

    task automatic test_counter_wrap();
        reset = 1'b0;
        drive(idle());
        #1;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 17; i++) begin
            apply(idle());
            advance();
        end
        n_checks++;
        if (cycleCount4 !== 4'd1 || cycleCount !== 32'd17) begin
            n_fail++; $display("FAIL counter_wrap: got %0d/%0d expected 1/17", cycleCount4, cycleCount);
        end
    endtask

    initial begin
        test_reset();
        test_mem_forward();
        test_load_use();
        test_mem_wb_priority();
        test_zero_dest();
        test_back_to_back();
        test_mid_run_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
